// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants for the five-stage core pipeline registers:
//               NOP instruction, per-stage control widths, per-stage kill
//               masks and the stage occupancy / state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Instruction presented by a stage that holds no valid entry.
    localparam logic [15:0] c_NOP_INSTR = 16'h0800;

    // Per-stage control word widths.
    localparam int c_IDEX_CTRL_W  = 24;
    localparam int c_EXMEM_CTRL_W = 24;

    // Side-effecting control bits (RegWrite, DMemEn, DMemWrite, Halt) that
    // must read 0 whenever the stage presents a bubble.
    localparam logic [23:0] c_IDEX_KILL  = 24'h00000F;
    localparam logic [23:0] c_EXMEM_KILL = 24'h00000F;

    // Occupancy encoding; it doubles as the handshake state encoding so the
    // occupancy output is the state register itself.
    localparam int          c_OCC_W     = 2;
    localparam logic [1:0]  c_OCC_EMPTY = 2'd0;
    localparam logic [1:0]  c_OCC_ONE   = 2'd1;
    localparam logic [1:0]  c_OCC_TWO   = 2'd2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_entry_reg
// Description : One pipeline entry (payload + control + instruction) with
//               load enable and synchronous clear.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_clr          - synchronous clear (wins over load)
//               i_load         - capture i_data/i_ctrl/i_instr
//               o_data/o_ctrl/o_instr - stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry_reg #(
    parameter int DATA_W  = 48,
    parameter int CTRL_W  = 24,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [CTRL_W-1:0]  i_ctrl,
    input  logic [INSTR_W-1:0] i_instr,
    output logic [DATA_W-1:0]  o_data,
    output logic [CTRL_W-1:0]  o_ctrl,
    output logic [INSTR_W-1:0] o_instr
);

    logic [DATA_W-1:0]  r_data;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [INSTR_W-1:0] r_instr;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_data  <= '0;
            r_ctrl  <= '0;
            r_instr <= '0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
            r_instr <= i_instr;
        end
    end

    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;
    assign o_instr = r_instr;

endmodule : pipe_entry_reg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised pipeline-stage register with valid/ready
//               handshake, optional two-entry skid buffer and bubble
//               insertion (masked control, NOP instruction when empty).
// Ports       : clk, rst                     - clock, sync active-high reset
//               in_valid/in_ready            - upstream handshake
//               in_data/in_ctrl/in_instr     - upstream entry
//               flush                        - drop held + incoming entries
//               out_valid/out_ready          - downstream handshake
//               out_data/out_ctrl/out_instr  - head entry (bubble if invalid)
//               occupancy                    - entries held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                  DATA_W    = 48,
    parameter int                  CTRL_W    = 24,
    parameter int                  INSTR_W   = 16,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = c_NOP_INSTR,
    parameter logic [CTRL_W-1:0]   KILL_MASK = '0,
    parameter bit                  SKID_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
);

    logic [c_OCC_W-1:0] r_state;
    logic [c_OCC_W-1:0] w_stateNext;
    logic               w_accept;
    logic               w_drain;
    logic               w_headLoad;
    logic               w_headFromSkid;
    logic               w_skidLoad;

    logic [DATA_W-1:0]  w_headData,  w_skidData,  w_headDataIn;
    logic [CTRL_W-1:0]  w_headCtrl,  w_skidCtrl,  w_headCtrlIn;
    logic [INSTR_W-1:0] w_headInstr, w_skidInstr, w_headInstrIn;

    assign w_accept = in_valid & in_ready;
    assign w_drain  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Handshake state machine (state == occupancy)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_OCC_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_headLoad     = 1'b0;
        w_headFromSkid = 1'b0;
        w_skidLoad     = 1'b0;
        if (flush) begin
            // Accept this cycle is dropped; a drain of the current head still
            // counts downstream, the stage simply ends up empty.
            w_stateNext = c_OCC_EMPTY;
        end else begin
            case (r_state)
                c_OCC_EMPTY: begin
                    if (w_accept) begin
                        w_stateNext = c_OCC_ONE;
                        w_headLoad  = 1'b1;
                    end
                end
                c_OCC_ONE: begin
                    if (w_accept && w_drain) begin
                        w_headLoad = 1'b1;
                    end else if (w_accept && SKID_EN) begin
                        // Without the skid buffer in_ready is low here, so
                        // this branch is only reachable with SKID_EN set.
                        w_stateNext = c_OCC_TWO;
                        w_skidLoad  = 1'b1;
                    end else if (w_drain) begin
                        w_stateNext = c_OCC_EMPTY;
                    end
                end
                c_OCC_TWO: begin
                    if (w_drain) begin
                        w_stateNext    = c_OCC_ONE;
                        w_headLoad     = 1'b1;
                        w_headFromSkid = 1'b1;
                    end
                end
                default: begin
                    w_stateNext = c_OCC_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ready generation
    // ------------------------------------------------------------------
    generate
        if (SKID_EN) begin : g_skidReady
            // Registered ready: low only while both entries are occupied.
            logic r_inReady;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_inReady <= 1'b1;
                end else begin
                    r_inReady <= (w_stateNext != c_OCC_TWO);
                end
            end
            assign in_ready = r_inReady;
        end else begin : g_passReady
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    assign w_headDataIn  = w_headFromSkid ? w_skidData  : in_data;
    assign w_headCtrlIn  = w_headFromSkid ? w_skidCtrl  : in_ctrl;
    assign w_headInstrIn = w_headFromSkid ? w_skidInstr : in_instr;

    // The head is not cleared by flush so that out_data keeps its last value.
    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .INSTR_W (INSTR_W)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_load  (w_headLoad),
        .i_data  (w_headDataIn),
        .i_ctrl  (w_headCtrlIn),
        .i_instr (w_headInstrIn),
        .o_data  (w_headData),
        .o_ctrl  (w_headCtrl),
        .o_instr (w_headInstr)
    );

    pipe_entry_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush),
        .i_load  (w_skidLoad),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .i_instr (in_instr),
        .o_data  (w_skidData),
        .o_ctrl  (w_skidCtrl),
        .o_instr (w_skidInstr)
    );

    // ------------------------------------------------------------------
    // Outputs with bubble insertion
    // ------------------------------------------------------------------
    assign out_valid = (r_state != c_OCC_EMPTY);
    assign occupancy = r_state;
    assign out_data  = w_headData;
    assign out_ctrl  = out_valid ? w_headCtrl : (w_headCtrl & ~KILL_MASK);
    assign out_instr = out_valid ? w_headInstr : NOP_INSTR;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. A skid build and a
//               single-entry build share one stimulus stream; each is
//               compared every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int             DW   = 48;
    localparam int             CW   = 24;
    localparam int             IW   = 16;
    localparam logic [CW-1:0]  KILL = 24'h00000F;
    localparam logic [IW-1:0]  NOP  = 16'h0800;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic [IW-1:0] instr;
    } entry_t;

    logic          clk = 1'b0;
    logic          r_rst, r_flush, r_inValid, r_outReady;
    logic [DW-1:0] r_inData;
    logic [CW-1:0] r_inCtrl;
    logic [IW-1:0] r_inInstr;

    logic          w_inReady1, w_outValid1, w_inReady0, w_outValid0;
    logic [DW-1:0] w_outData1, w_outData0;
    logic [CW-1:0] w_outCtrl1, w_outCtrl0;
    logic [IW-1:0] w_outInstr1, w_outInstr0;
    logic [1:0]    w_occ1, w_occ0;

    // Reference model: ordered list of held entries plus the control word of
    // the most recent entry that sat at the head.
    entry_t        m1[$];
    entry_t        m0[$];
    logic [CW-1:0] lastCtrl1, lastCtrl0;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .INSTR_W(IW), .NOP_INSTR(NOP),
        .KILL_MASK(KILL), .SKID_EN(1'b1)
    ) dut1 (
        .clk(clk), .rst(r_rst), .in_valid(r_inValid), .in_ready(w_inReady1),
        .in_data(r_inData), .in_ctrl(r_inCtrl), .in_instr(r_inInstr),
        .flush(r_flush), .out_valid(w_outValid1), .out_ready(r_outReady),
        .out_data(w_outData1), .out_ctrl(w_outCtrl1), .out_instr(w_outInstr1),
        .occupancy(w_occ1)
    );

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .INSTR_W(IW), .NOP_INSTR(NOP),
        .KILL_MASK(KILL), .SKID_EN(1'b0)
    ) dut0 (
        .clk(clk), .rst(r_rst), .in_valid(r_inValid), .in_ready(w_inReady0),
        .in_data(r_inData), .in_ctrl(r_inCtrl), .in_instr(r_inInstr),
        .flush(r_flush), .out_valid(w_outValid0), .out_ready(r_outReady),
        .out_data(w_outData0), .out_ctrl(w_outCtrl0), .out_instr(w_outInstr0),
        .occupancy(w_occ0)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkDut(input string name, input logic obsValid, input logic obsReady,
                            input logic [1:0] obsOcc, input logic [DW-1:0] obsData,
                            input logic [CW-1:0] obsCtrl, input logic [IW-1:0] obsInstr,
                            input int size, input entry_t front, input logic expReady,
                            input logic [CW-1:0] lastCtrl);
        checkVal({name, ".occupancy"}, 64'(obsOcc), 64'(size));
        checkVal({name, ".out_valid"}, 64'(obsValid), 64'(size > 0));
        checkVal({name, ".in_ready"}, 64'(obsReady), 64'(expReady));
        if (size > 0) begin
            checkVal({name, ".out_data"},  64'(obsData),  64'(front.data));
            checkVal({name, ".out_ctrl"},  64'(obsCtrl),  64'(front.ctrl));
            checkVal({name, ".out_instr"}, 64'(obsInstr), 64'(front.instr));
        end else begin
            checkVal({name, ".bubble_ctrl"},  64'(obsCtrl),  64'(lastCtrl & ~KILL));
            checkVal({name, ".bubble_instr"}, 64'(obsInstr), 64'(NOP));
        end
    endtask

    // One clock: check both DUTs against the model mid-cycle, then advance
    // the model with the handshake outcome of this cycle.
    task automatic tick();
        bit     acc1, acc0, dr1, dr0;
        entry_t cur;
        entry_t f1, f0;
        @(negedge clk);
        f1 = (m1.size() > 0) ? m1[0] : '0;
        f0 = (m0.size() > 0) ? m0[0] : '0;
        checkDut("skid", w_outValid1, w_inReady1, w_occ1, w_outData1, w_outCtrl1, w_outInstr1,
                 m1.size(), f1, m1.size() < 2, lastCtrl1);
        checkDut("single", w_outValid0, w_inReady0, w_occ0, w_outData0, w_outCtrl0, w_outInstr0,
                 m0.size(), f0, (m0.size() == 0) || r_outReady, lastCtrl0);
        cur  = '{data: r_inData, ctrl: r_inCtrl, instr: r_inInstr};
        acc1 = r_inValid && (m1.size() < 2);
        acc0 = r_inValid && ((m0.size() == 0) || r_outReady);
        dr1  = (m1.size() > 0) && r_outReady;
        dr0  = (m0.size() > 0) && r_outReady;
        @(posedge clk);
        if (r_rst) begin
            m1.delete(); m0.delete();
            lastCtrl1 = '0; lastCtrl0 = '0;
        end else if (r_flush) begin
            m1.delete(); m0.delete();
        end else begin
            if (dr1) void'(m1.pop_front());
            if (acc1) m1.push_back(cur);
            if (dr0) void'(m0.pop_front());
            if (acc0) m0.push_back(cur);
        end
        if (m1.size() > 0) lastCtrl1 = m1[0].ctrl;
        if (m0.size() > 0) lastCtrl0 = m0[0].ctrl;
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
        r_inValid = v;
        r_inData  = d;
        r_inCtrl  = c;
        r_inInstr = d[IW-1:0] ^ 16'h1000;
    endtask

    initial begin
        r_rst = 1'b1; r_flush = 1'b0; r_outReady = 1'b0;
        drive(1'b0, '0, '0);
        lastCtrl1 = '0; lastCtrl0 = '0;
        repeat (2) @(posedge clk);
        #1;
        r_rst = 1'b0;
        #2;
        checkVal("reset.out_valid", 64'(w_outValid1), 64'd0);
        checkVal("reset.in_ready",  64'(w_inReady1),  64'd1);
        checkVal("reset.occupancy", 64'(w_occ1),      64'd0);
        checkVal("reset.out_instr", 64'(w_outInstr1), 64'h0800);
        checkVal("reset.out_ctrl",  64'(w_outCtrl1),  64'd0);

        // Streaming 1..8 with the sink always ready.
        r_outReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), CW'(i * 3));
            tick();
        end
        drive(1'b0, '0, '0);
        repeat (2) tick();

        // Backpressure: A, B, C with the sink stalled, then release.
        r_outReady = 1'b0;
        drive(1'b1, 48'hA, 24'h00A0A0); tick();
        drive(1'b1, 48'hB, 24'h00B0B0); tick();
        drive(1'b1, 48'hC, 24'h00C0C0); tick();
        tick();
        r_outReady = 1'b1;
        repeat (2) tick();
        drive(1'b0, '0, '0);
        repeat (3) tick();

        // Flush with two entries held while D is offered.
        r_outReady = 1'b0;
        drive(1'b1, 48'h1A, 24'hFFFFFF); tick();
        drive(1'b1, 48'h1B, 24'hFFFFFF); tick();
        r_flush = 1'b1;
        drive(1'b1, 48'hD, 24'h0D0D0D); tick();
        r_flush = 1'b0;
        drive(1'b0, '0, '0);
        #2;
        checkVal("flush.out_valid", 64'(w_outValid1), 64'd0);
        checkVal("flush.occupancy", 64'(w_occ1),      64'd0);
        checkVal("flush.out_instr", 64'(w_outInstr1), 64'h0800);
        checkVal("flush.kill_bits", 64'(w_outCtrl1 & KILL), 64'd0);
        r_outReady = 1'b1;
        repeat (2) tick();

        // Kill mask: hold an all-ones control word, drain it, leave empty.
        r_outReady = 1'b0;
        drive(1'b1, 48'h55, 24'hFFFFFF); tick();
        drive(1'b0, '0, '0);
        r_outReady = 1'b1;
        tick();
        #2;
        checkVal("kill.skid.out_ctrl",   64'(w_outCtrl1), 64'hFFFFF0);
        checkVal("kill.single.out_ctrl", 64'(w_outCtrl0), 64'hFFFFF0);
        tick();

        // rst and flush together with an offered entry.
        r_rst = 1'b1; r_flush = 1'b1;
        drive(1'b1, 48'h77, 24'hFFFFFF); tick();
        r_rst = 1'b0; r_flush = 1'b0;
        drive(1'b0, '0, '0);
        #2;
        checkVal("rstflush.out_valid", 64'(w_outValid0), 64'd0);
        checkVal("rstflush.occupancy", 64'(w_occ0),      64'd0);
        checkVal("rstflush.in_ready",  64'(w_inReady0),  64'd1);
        checkVal("rstflush.out_ctrl",  64'(w_outCtrl0),  64'd0);
        checkVal("rstflush.out_instr", 64'(w_outInstr0), 64'h0800);

        // Single-entry streaming with a toggling sink.
        for (int i = 0; i < 12; i++) begin
            r_outReady = i[0];
            drive(1'b1, DW'(100 + i), CW'(i));
            tick();
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r_outReady = ($urandom_range(0, 3) != 0);
            r_flush    = ($urandom_range(0, 15) == 0);
            r_rst      = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 2) != 0, {16'($urandom), $urandom}, 24'($urandom));
            tick();
        end
        r_rst = 1'b0; r_flush = 1'b0;
        drive(1'b0, '0, '0);
        r_outReady = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register for the five-stage core. It generalises the fixed-field stage latches into one block that carries a generic data payload, a control word and an instruction word. It replaces the global stall enable with a per-stage valid/ready handshake, backed by a two-entry skid buffer so that ready does not feed through combinationally. It also adds flush/bubble insertion: side-effecting control bits are forced low and the instruction reads as NOP whenever the stage holds no valid entry.

Parameters:
DATA_W, 48, width of data payload (operands, immediate, PC+2)
CTRL_W, 24, width of control word
INSTR_W, 16, instruction width
NOP_INSTR, 16'h0800, instruction value presented when no valid entry
KILL_MASK, 24'h0, ctrl bits forced to 0 when out_valid=0 (RegWrite, DMemEn, DMemWrite, Halt)
SKID_EN, 1, 1 = two-entry skid buffer; 0 = single entry with combinational in_ready

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept
in_data  in  DATA_W  payload
in_ctrl  in  CTRL_W  control word
in_instr  in  INSTR_W  instruction
flush  in  1  discard all held entries and any entry accepted this cycle
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_data  out  DATA_W  head payload
out_ctrl  out  CTRL_W  head control, masked when invalid
out_instr  out  INSTR_W  head instruction, or NOP_INSTR when invalid
occupancy  out  2  entries held (0..2)

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: all valid flags 0; out_valid=0; occupancy=0; in_ready=1 (SKID_EN=1); out_data=0; out_ctrl=0; out_instr=NOP_INSTR.
- Transfer rules: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: an accepted entry appears at out_* on the next cycle when the stage was empty or draining; latency is 1.
- State machine (SKID_EN=1), states EMPTY, ONE, TWO:
  - EMPTY: accept -> ONE.
  - ONE: accept & drain -> ONE, head reloaded from input. accept & ~drain -> TWO, input written to the skid entry. ~accept & drain -> EMPTY.
  - TWO: in_ready=0. drain -> ONE, skid entry moves to the head.
- in_ready is registered: in_ready = (state != TWO). It never depends on out_ready combinationally.
- SKID_EN=0: single entry; in_ready = ~out_valid | out_ready (combinational). The TWO state is unreachable and occupancy never exceeds 1.
- Flush: synchronous and highest priority after rst. Next state = EMPTY, and any accept in the same cycle is dropped. A drain in the flush cycle still completes for the current head.
- Invalid outputs: when out_valid=0, out_ctrl = stored_ctrl & ~KILL_MASK and out_instr = NOP_INSTR. out_data holds its last value; no requirement is placed on it.
- Hold: with out_valid=1 and out_ready=0, out_* stay stable and unchanged until drain.
- Payload ordering is strictly FIFO; no entry is duplicated or lost except by flush.
- Simultaneous rst & flush: rst wins; results are identical to reset.
- Reset or flush mid-transfer: a held skid entry is discarded with no partial state.

Decomposition:
- Shared package pipe_pkg holds the NOP_INSTR constant, per-stage CTRL_W values, per-stage KILL_MASK constants (IDEX_KILL, EXMEM_KILL) and the occupancy encoding.
- One sub-module: pipe_entry_reg, a DATA_W+CTRL_W+INSTR_W register with load enable and synchronous clear. It is instantiated for the head and the skid entry.
- The state machine lives in the top level.

Test Plan:
- Reset: assert rst for 2 cycles -> out_valid=0, in_ready=1, occupancy=0, out_instr=16'h0800, out_ctrl=0.
- Streaming: in_valid=1 with data 1..8 and out_ready=1 throughout -> out_data 1..8 on consecutive cycles, one cycle later; occupancy stays 1.
- Backpressure: out_ready=0 while sending A, B, C -> A held at output, B goes to skid, in_ready=0 and C stalls. Release out_ready -> order is A, B, C and occupancy follows 1, 2, 2, 1.
- Flush: with occupancy=2, assert flush while in_valid carries D -> next cycle out_valid=0, occupancy=0, out_instr=16'h0800. Masked ctrl bits read 0 and D never appears.
- Kill mask: KILL_MASK=24'h00000F with a held entry ctrl=24'hFFFFFF, drained and not refilled -> out_ctrl=24'hFFFFF0.
- Reset priority: SKID_EN=0 build, rst and flush together with in_valid=1 -> reset state. Single-entry streaming then gives in_ready = out_ready while full.
